lcd_dfa_ram_arbiter: RTL

LCD_DFA_RAM_ARBITER -- requirements
Module: lcd_dfa_ram_arbiter

---
 rtl/lcd_dfa_ram_arbiter_if.sv | 48 ++++
 rtl/lcd_dfa_ram_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/lcd_dfa_ram_arbiter_if.sv
// Requester and RAM-side bus bundle for the two-port shared-RAM arbiter.
// The arbiter binds to the slave modport; the requesters and RAM bind to the master modport.
interface lcd_dfa_ram_arbiter_if #(
  parameter int ADDRESS_WIDTH = 1,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] a_wr_address, b_wr_address;
  logic [DATA_WIDTH-1:0]    a_wr_writedata, b_wr_writedata;
  logic                     a_wr_write, b_wr_write;
  logic                     a_wr_waitrequest, b_wr_waitrequest;
  logic [ADDRESS_WIDTH-1:0] a_rd_address, b_rd_address;
  logic                     a_rd_read, b_rd_read;
  logic                     a_rd_waitrequest, b_rd_waitrequest;
  logic [DATA_WIDTH-1:0]    a_rd_readdata, b_rd_readdata;
  logic                     a_rd_readdatavalid, b_rd_readdatavalid;
  logic [ADDRESS_WIDTH-1:0] ram_wr_address;
  logic [DATA_WIDTH-1:0]    ram_wr_writedata;
  logic                     ram_wr_write;
  logic                     ram_wr_waitrequest;
  logic [ADDRESS_WIDTH-1:0] ram_rd_address;
  logic [DATA_WIDTH-1:0]    ram_rd_readdata;

  modport slave (
    input  a_wr_address, b_wr_address, a_wr_writedata, b_wr_writedata,
    input  a_wr_write, b_wr_write,
    output a_wr_waitrequest, b_wr_waitrequest,
    input  a_rd_address, b_rd_address, a_rd_read, b_rd_read,
    output a_rd_waitrequest, b_rd_waitrequest,
    output a_rd_readdata, b_rd_readdata, a_rd_readdatavalid, b_rd_readdatavalid,
    output ram_wr_address, ram_wr_writedata, ram_wr_write,
    input  ram_wr_waitrequest,
    output ram_rd_address,
    input  ram_rd_readdata
  );

  modport master (
    output a_wr_address, b_wr_address, a_wr_writedata, b_wr_writedata,
    output a_wr_write, b_wr_write,
    input  a_wr_waitrequest, b_wr_waitrequest,
    output a_rd_address, b_rd_address, a_rd_read, b_rd_read,
    input  a_rd_waitrequest, b_rd_waitrequest,
    input  a_rd_readdata, b_rd_readdata, a_rd_readdatavalid, b_rd_readdatavalid,
    input  ram_wr_address, ram_wr_writedata, ram_wr_write,
    output ram_wr_waitrequest,
    input  ram_rd_address,
    output ram_rd_readdata
  );
endinterface

// File: rtl/lcd_dfa_ram_arbiter.sv
// Round-robin arbiter sharing one RAM write port and one RAM read port between
// requesters A and B; reads return one cycle after acceptance, one outstanding at most.
module lcd_dfa_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 1,
  parameter int DATA_WIDTH    = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  lcd_dfa_ram_arbiter_if.slave   bus
);

  // last_q: 0 = A won last, 1 = B won last; reset to B so A wins first contention
  logic                  wlast_q, wlast_d;
  logic                  rlast_q, rlast_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_owner_q, pend_owner_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic                     busy;
  logic                     wgnt_a, wgnt_b, wr_acc;
  logic                     rgnt_a, rgnt_b, rd_acc;
  logic                     a_strobe, b_strobe;
  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  always_comb begin
    // reset is treated as a RAM stall so every requester sees waitrequest
    busy     = bus.ram_wr_waitrequest | ~reset_n;

    wgnt_a   = bus.a_wr_write & (~bus.b_wr_write | wlast_q);
    wgnt_b   = bus.b_wr_write & (~bus.a_wr_write | ~wlast_q);
    wr_acc   = (wgnt_a | wgnt_b) & ~busy;
    wr_addr  = wgnt_b ? bus.b_wr_address   : bus.a_wr_address;
    wr_data  = wgnt_b ? bus.b_wr_writedata : bus.a_wr_writedata;
    wlast_d  = wr_acc ? wgnt_b : wlast_q;

    rgnt_a   = bus.a_rd_read & (~bus.b_rd_read | rlast_q);
    rgnt_b   = bus.b_rd_read & (~bus.a_rd_read | ~rlast_q);
    rd_acc   = (rgnt_a | rgnt_b) & ~busy;
    rd_addr  = rgnt_b ? bus.b_rd_address : bus.a_rd_address;
    rlast_d  = rd_acc ? rgnt_b : rlast_q;

    pend_valid_d = rd_acc;
    pend_owner_d = rd_acc ? rgnt_b : pend_owner_q;

    // RAM data is routed straight through on the strobe and captured for holding
    a_strobe  = pend_valid_q & ~pend_owner_q;
    b_strobe  = pend_valid_q &  pend_owner_q;
    a_rdata_d = a_strobe ? bus.ram_rd_readdata : a_rdata_q;
    b_rdata_d = b_strobe ? bus.ram_rd_readdata : b_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wlast_q      <= 1'b1;
      rlast_q      <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      wlast_q      <= wlast_d;
      rlast_q      <= rlast_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign bus.ram_wr_address     = wr_addr;
  assign bus.ram_wr_writedata   = wr_data;
  assign bus.ram_wr_write       = wr_acc;
  assign bus.a_wr_waitrequest   = busy | (bus.a_wr_write & ~wgnt_a);
  assign bus.b_wr_waitrequest   = busy | (bus.b_wr_write & ~wgnt_b);

  assign bus.ram_rd_address     = rd_addr;
  assign bus.a_rd_waitrequest   = busy | (bus.a_rd_read & ~rgnt_a);
  assign bus.b_rd_waitrequest   = busy | (bus.b_rd_read & ~rgnt_b);
  assign bus.a_rd_readdatavalid = a_strobe;
  assign bus.b_rd_readdatavalid = b_strobe;
  assign bus.a_rd_readdata      = a_rdata_d;
  assign bus.b_rd_readdata      = b_rdata_d;

endmodule
